// File: rtl/memory_interface.sv
// ============================================================================
// Module      : memory_interface
// Description : Memory-side datapath stage with MAR, MDR and a word-addressed
//               RAM. It serves edge-triggered Read/Write requests and reports
//               completion on Ready. Build macro MEM_WAIT_EN enables the
//               WAIT_STATES wait-state counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_interface #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] MDR_q,
  output logic [ADDR_W-1:0] MAR_q,
  output logic              Busy,
  output logic              Ready,
  output logic              Conflict
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_RD_WAIT = 2'd1;
  localparam logic [1:0] c_WR_WAIT = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [ADDR_W-1:0] r_mar;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_start_addr;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic              r_read_d;
  logic              r_write_d;
  logic              r_ready;
  logic              r_conflict;
  logic              w_rd_rise;
  logic              w_wr_rise;
  logic              w_start_rd;
  logic              w_start_wr;
  logic              w_done;
  logic              w_rd_done;
  logic              w_wr_done;

  assign w_rd_rise    = Read  & ~r_read_d;
  assign w_wr_rise    = Write & ~r_write_d;
  // MARin in the start cycle forwards the bus address straight into the access.
  assign w_start_addr = MARin ? BusMuxOut[ADDR_W-1:0] : r_mar;
  assign w_wr_data    = MDRin ? BusMuxOut : r_mdr;

`ifdef MEM_WAIT_EN
  localparam logic [3:0] c_WAIT = 4'(WAIT_STATES);

  logic [3:0] r_wait;

  assign w_done = (r_wait == 4'd0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wait <= 4'd0;
    end else if (w_start_rd || w_start_wr) begin
      r_wait <= c_WAIT;
    end else if ((r_state != c_IDLE) && !w_done) begin
      r_wait <= r_wait - 4'd1;
    end
  end
`else
  localparam int c_unused_wait_states = WAIT_STATES;

  assign w_done = 1'b1;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_wr_rise) begin
          w_next_state = c_WR_WAIT;
        end else if (w_rd_rise) begin
          w_next_state = c_RD_WAIT;
        end
      end
      c_RD_WAIT, c_WR_WAIT: begin
        if (w_done) begin
          w_next_state = c_IDLE;
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_start_wr = (r_state == c_IDLE) && w_wr_rise;
    w_start_rd = (r_state == c_IDLE) && w_rd_rise && !w_wr_rise;
    w_rd_done  = (r_state == c_RD_WAIT) && w_done;
    w_wr_done  = (r_state == c_WR_WAIT) && w_done;
    Busy       = (r_state != c_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_mar      <= '0;
      r_mdr      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_read_d   <= 1'b0;
      r_write_d  <= 1'b0;
      r_ready    <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_read_d   <= Read;
      r_write_d  <= Write;
      r_ready    <= w_rd_done || w_wr_done;
      r_conflict <= w_start_wr && w_rd_rise;
      if (MARin) begin
        r_mar <= BusMuxOut[ADDR_W-1:0];
      end
      if (w_start_rd || w_start_wr) begin
        r_addr <= w_start_addr;
      end
      if (w_start_wr) begin
        r_wdata <= w_wr_data;
      end
      // Read data takes precedence over a same-cycle MDRin load.
      if (w_rd_done) begin
        r_mdr <= r_mem[r_addr];
      end else if (MDRin) begin
        r_mdr <= BusMuxOut;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset && w_wr_done) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign MDR_q    = r_mdr;
  assign MAR_q    = r_mar;
  assign Ready    = r_ready;
  assign Conflict = r_conflict;

endmodule

`default_nettype wire

// File: tb/tb_memory_interface.sv
// ============================================================================
// Module      : tb_memory_interface
// Description : Directed self-checking bench for memory_interface; expected
//               MDR values queue up at request time and are checked at Ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_interface;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
`ifdef MEM_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic [DATA_W-1:0] BusMuxOut = '0;
  logic              MARin = 1'b0;
  logic              MDRin = 1'b0;
  logic              Read = 1'b0;
  logic              Write = 1'b0;
  wire  [DATA_W-1:0] MDR_q;
  wire  [ADDR_W-1:0] MAR_q;
  wire               Busy;
  wire               Ready;
  wire               Conflict;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] sb_q[$];

  memory_interface #(
    .WAIT_STATES(2),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .BusMuxOut(BusMuxOut),
    .MARin    (MARin),
    .MDRin    (MDRin),
    .Read     (Read),
    .Write    (Write),
    .MDR_q    (MDR_q),
    .MAR_q    (MAR_q),
    .Busy     (Busy),
    .Ready    (Ready),
    .Conflict (Conflict)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs from just after the start edge until completion, then releases requests.
  task automatic complete_access(input string tag);
    int cyc;
    logic [31:0] exp;
    cyc = 0;
    while (Ready !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
      MARin = 1'b0;
      MDRin = 1'b0;
      if (Ready !== 1'b1) check({tag, " busy_hold"}, Busy, 1);
    end
    check({tag, " ready"}, Ready, 1);
    check({tag, " latency"}, cyc, W + 1);
    check({tag, " busy_done"}, Busy, 0);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, " mdr"}, MDR_q, exp);
    Read  = 1'b0;
    Write = 1'b0;
    step();
    check({tag, " ready_drop"}, Ready, 0);
    check({tag, " conflict_drop"}, Conflict, 0);
  endtask

  task automatic finish_access(input string tag, input logic exp_conflict);
    step();
    check({tag, " busy_start"}, Busy, 1);
    check({tag, " conflict"}, Conflict, exp_conflict);
    MARin = 1'b0;
    MDRin = 1'b0;
    complete_access(tag);
  endtask

  task automatic load_mar(input logic [31:0] a);
    BusMuxOut = a;
    MARin = 1'b1;
    step();
    MARin = 1'b0;
  endtask

  task automatic write_op(input logic [31:0] a, input logic [31:0] d, input string tag);
    load_mar(a);
    BusMuxOut = d;
    MDRin = 1'b1;
    Write = 1'b1;
    sb_q.push_back(d);
    finish_access(tag, 1'b0);
  endtask

  task automatic read_op(input logic [31:0] a, input logic [31:0] exp, input string tag);
    load_mar(a);
    Read = 1'b1;
    sb_q.push_back(exp);
    finish_access(tag, 1'b0);
  endtask

  initial begin
    int pulses;
    logic seen;

    repeat (3) step();
    check("rst mar", MAR_q, 0);
    check("rst mdr", MDR_q, 0);
    check("rst busy", Busy, 0);
    check("rst ready", Ready, 0);
    check("rst conflict", Conflict, 0);
    Reset = 1'b0;
    step();

    write_op(32'h010, 32'hDEADBEEF, "preload010");
    read_op(32'h010, 32'hDEADBEEF, "read010");

    write_op(32'h1FF, 32'h12345678, "store1ff");
    read_op(32'h1FF, 32'h12345678, "read1ff");

    // Address forwarded from the bus in the start cycle (MAR currently 0x1FF).
    BusMuxOut = 32'h010;
    MARin = 1'b1;
    Read = 1'b1;
    sb_q.push_back(32'hDEADBEEF);
    finish_access("fwdread", 1'b0);
    check("fwd mar", MAR_q, 9'h010);

    // A held Read level produces a single access.
    load_mar(32'h1FF);
    Read = 1'b1;
    sb_q.push_back(32'h12345678);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (Ready === 1'b1) begin
        pulses++;
        check("held mdr", MDR_q, sb_q.pop_front());
      end
    end
    check("held pulses", pulses, 1);
    Read = 1'b0;
    step();
    read_op(32'h1FF, 32'h12345678, "held_unchanged");

    // Simultaneous rise: write of current MDR wins.
    load_mar(32'h005);
    BusMuxOut = 32'hA5A5A5A5;
    MDRin = 1'b1;
    step();
    MDRin = 1'b0;
    BusMuxOut = '0;
    check("conf mdr_load", MDR_q, 32'hA5A5A5A5);
    Read = 1'b1;
    Write = 1'b1;
    sb_q.push_back(32'hA5A5A5A5);
    finish_access("conflict", 1'b1);
    read_op(32'h005, 32'hA5A5A5A5, "read005");

    // Reset one cycle into a write aborts it.
    write_op(32'h020, 32'h00000007, "pre020");
    load_mar(32'h020);
    BusMuxOut = 32'hFFFFFFFF;
    MDRin = 1'b1;
    Write = 1'b1;
    step();
    check("rstmid busy", Busy, 1);
    MDRin = 1'b0;
    Write = 1'b0;
    Reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (Ready === 1'b1) seen = 1'b1;
    end
    check("rstmid ready_seen", seen, 0);
    check("rstmid mdr", MDR_q, 0);
    check("rstmid busy_after", Busy, 0);
    check("rstmid mar", MAR_q, 0);
    Reset = 1'b0;
    step();
    read_op(32'h020, 32'h00000007, "read020");

    // Address wrap, and MARin while a read is in flight.
    write_op(32'h044, 32'h44444444, "pre044");
    write_op(32'h203, 32'h0BADF00D, "pre003");
    load_mar(32'h00000203);
    check("wrap mar", MAR_q, 9'h003);
    Read = 1'b1;
    sb_q.push_back(32'h0BADF00D);
    step();
    check("wrap busy_start", Busy, 1);
    BusMuxOut = 32'h044;
    MARin = 1'b1;
    complete_access("wrapread");
    check("wrap mar_after", MAR_q, 9'h044);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
